// File: rtl/aes_enc_core.sv
// Iterative AES-128 encryption core with a key-expansion handshake.
// One SubBytes+ShiftRows step and one MixColumns step per round,
// followed by an AddRoundKey step that waits for the matching round key.

// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_inv;

    // x^254 is the inverse of x (and maps 0 to 0), built by square-and-multiply.
    always_comb begin
        logic [7:0] p;
        logic [7:0] r;
        p = i_byte;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        w_inv = r;
    end

    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;
endmodule

// States:
//   S_IDLE     | no block in flight, busy low
//   S_WAIT_KEY | waiting for round_key whose index equals the round counter
//   S_SUB      | SubBytes + ShiftRows on the state register
//   S_MIX      | MixColumns on the state register (skipped in the last round)
//   S_DONE     | ciphertext latched, done high for this one cycle
module aes_enc_core #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] data_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out,
    output logic         key_enable,
    input  logic         key_ready,
    input  logic [3:0]   key_transform,
    input  logic [127:0] round_key,
    output logic         key_ack,
    output logic         key_err
);
    localparam logic [3:0] LP_NR = 4'(NR);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_KEY, S_SUB, S_MIX, S_DONE} state_t;

    state_t         r_fsm;
    state_t         w_fsm_nxt;
    logic [127:0]   r_state;
    logic [127:0]   w_state_nxt;
    logic [3:0]     r_round;
    logic [3:0]     w_round_nxt;
    logic [127:0]   r_data_out;
    logic [127:0]   w_dout_nxt;
    logic           r_key_err;
    logic           w_err_nxt;
    logic           w_consume;
    logic [7:0]     w_sb [16];
    logic [127:0]   w_shifted;
    logic [127:0]   w_mixed;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state lives at [127-8i -: 8]; row r of column c is byte 4c+r.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (.i_byte(r_state[127-8*i -: 8]), .o_byte(w_sb[i]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_shifted[127-8*(4*c+r) -: 8] = w_sb[4*((c+r)%4)+r];
        end

        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = r_state[127-32*c -: 8];
        assign w_a1 = r_state[119-32*c -: 8];
        assign w_a2 = r_state[111-32*c -: 8];
        assign w_a3 = r_state[103-32*c -: 8];
        assign w_mixed[127-32*c -: 8] = xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mixed[119-32*c -: 8] = w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3;
        assign w_mixed[111-32*c -: 8] = w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3;
        assign w_mixed[103-32*c -: 8] = xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fsm <= S_IDLE;
        else          r_fsm <= w_fsm_nxt;
    end

    // Next-state, datapath next values and the consume decision.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_dout_nxt  = r_data_out;
        w_err_nxt   = r_key_err;
        w_consume   = 1'b0;
        case (r_fsm)
            S_IDLE, S_DONE: begin
                w_fsm_nxt = S_IDLE;
                if (start) begin
                    w_state_nxt = data_in;
                    w_round_nxt = 4'd0;
                    w_err_nxt   = 1'b0;
                    w_fsm_nxt   = S_WAIT_KEY;
                end
            end
            S_WAIT_KEY: begin
                if (key_ready) begin
                    if (key_transform == r_round) begin
                        w_consume   = 1'b1;
                        w_state_nxt = r_state ^ round_key;
                        if (r_round == LP_NR) begin
                            w_dout_nxt = r_state ^ round_key;
                            w_fsm_nxt  = S_DONE;
                        end else begin
                            w_round_nxt = r_round + 4'd1;
                            w_fsm_nxt   = S_SUB;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_SUB: begin
                w_state_nxt = w_shifted;
                w_fsm_nxt   = (r_round < LP_NR) ? S_MIX : S_WAIT_KEY;
            end
            S_MIX: begin
                w_state_nxt = w_mixed;
                w_fsm_nxt   = S_WAIT_KEY;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // Datapath, round counter, ciphertext holding register and sticky key error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= '0;
            r_round    <= '0;
            r_data_out <= '0;
            r_key_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_round    <= w_round_nxt;
            r_data_out <= w_dout_nxt;
            r_key_err  <= w_err_nxt;
        end
    end

    // key_ack is the consume decision itself, so it is high exactly in the
    // cycle whose closing edge latches round_key.
    assign busy       = (r_fsm == S_WAIT_KEY) || (r_fsm == S_SUB) || (r_fsm == S_MIX);
    assign done       = (r_fsm == S_DONE);
    assign key_enable = busy;
    assign key_ack    = w_consume;
    assign data_out   = r_data_out;
    assign key_err    = r_key_err;
endmodule

// File: tb/tb_aes_enc_core.sv
// Bench for aes_enc_core: the key expansion is modelled here, expected
// ciphertexts are the published AES-128 test vectors held in a scoreboard.
module tb_aes_enc_core;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] data_in;
    logic         busy;
    logic         done;
    logic [127:0] data_out;
    logic         key_enable;
    logic         key_ready;
    logic [3:0]   key_transform;
    logic [127:0] round_key;
    logic         key_ack;
    logic         key_err;

    aes_enc_core #(.NR(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
        .busy(busy), .done(done), .data_out(data_out), .key_enable(key_enable),
        .key_ready(key_ready), .key_transform(key_transform), .round_key(round_key),
        .key_ack(key_ack), .key_err(key_err)
    );

    always #5 clk = ~clk;

    int n_applied = 0;
    int n_miss    = 0;
    int ack_cnt   = 0;
    int done_cnt  = 0;
    int key_delay = 0;
    int bad_cnt   = 0;
    logic [127:0] rk [0:10];
    logic [127:0] sb [$];
    int exp_t [0:255];
    int log_t [0:255];

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           delay;
        int           lat;
    } vec_t;
    vec_t vecs [4];

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from log/antilog tables over generator 0x03.
    function automatic logic [7:0] sbx(input logic [7:0] x);
        logic [7:0] b;
        b = (x == 8'h00) ? 8'h00 : 8'(exp_t[(255 - log_t[x]) % 255]);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_keys(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbx(t[31:24]), sbx(t[23:16]), sbx(t[15:8]), sbx(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Key expansion stand-in: presents the next round key once the core is
    // back in its wait state plus key_delay cycles; optional wrong-index
    // cycles are injected in front of round key 1.
    initial begin
        int idx;
        int wcnt;
        key_ready = 1'b0;
        key_transform = 4'd0;
        round_key = '0;
        idx = 0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!key_enable) begin
                key_ready = 1'b0;
                idx = 0;
                wcnt = key_delay;
            end else if (idx <= 10) begin
                if (wcnt > 0) begin
                    key_ready = 1'b0;
                    wcnt--;
                end else if (bad_cnt > 0 && idx == 1) begin
                    key_ready = 1'b1;
                    key_transform = 4'd3;
                    round_key = rk[3];
                    bad_cnt--;
                end else begin
                    key_ready = 1'b1;
                    key_transform = 4'(idx);
                    round_key = rk[idx];
                end
            end else begin
                key_ready = 1'b0;
            end
            #3;
            if (key_ack) begin
                ack_cnt++;
                idx++;
                wcnt = key_delay + ((idx == 10) ? 1 : 2);
            end
        end
    end

    // Scoreboard consumer: every done pops and compares one expected ciphertext.
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_applied++;
                    n_miss++;
                    $display("FAIL unexpected_done: got done with data_out %h, expected no done", data_out);
                end else begin
                    check("ciphertext", data_out, sb.pop_front());
                end
            end
        end
    end

    task automatic start_block(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct);
        expand_keys(key);
        data_in = pt;
        start = 1'b1;
        sb.push_back(ct);
        ack_cnt = 0;
    endtask

    task automatic wait_done(input int lat, input int restart_at);
        int n;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 128'(busy), 128'(1));
        check("key_err_cleared", 128'(key_err), 128'(0));
        n = 0;
        while (!done && n < 600) begin
            @(negedge clk);
            n++;
            if (restart_at != 0 && n == restart_at) begin
                data_in = ~data_in;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("latency", 128'(n), 128'(lat));
        check("busy_at_done", 128'(busy), 128'(0));
    endtask

    task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct,
                             input int delay, input int lat, input int restart_at, input logic exp_err);
        key_delay = delay;
        @(negedge clk);
        start_block(key, pt, ct);
        wait_done(lat, restart_at);
        check("ack_count", 128'(ack_cnt), 128'(11));
        check("key_err", 128'(key_err), 128'(exp_err));
        @(negedge clk);
        check("done_one_cycle", 128'(done), 128'(0));
        check("data_out_held", data_out, ct);
    endtask

    initial begin
        int dc;
        for (int i = 0; i < 256; i++) begin
            exp_t[i] = 0;
            log_t[i] = 0;
        end
        begin
            logic [7:0] e;
            e = 8'h01;
            for (int i = 0; i < 255; i++) begin
                exp_t[i] = int'(e);
                log_t[e] = i;
                e = e ^ xt(e);
            end
        end

        vecs[0] = '{K_C1, P_C1, C_C1, 0, 30};
        vecs[1] = '{K_B,  P_B,  C_B,  5, 85};
        vecs[2] = '{K_C1, P_C1, C_C1, 2, 52};
        vecs[3] = '{K_B,  P_B,  C_B,  0, 30};

        reset_n = 1'b0;
        start = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_data_out", data_out, 128'(0));
        check("rst_key_enable", 128'(key_enable), 128'(0));
        check("rst_key_ack", 128'(key_ack), 128'(0));
        check("rst_key_err", 128'(key_err), 128'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++)
            run_block(vecs[v].key, vecs[v].pt, vecs[v].ct, vecs[v].delay, vecs[v].lat, 0, 1'b0);

        // Second start around round 4 must be ignored.
        dc = done_cnt;
        run_block(K_C1, P_C1, C_C1, 0, 30, 11, 1'b0);
        repeat (40) @(negedge clk);
        check("single_done", 128'(done_cnt), 128'(dc + 1));

        // New start in the DONE cycle: accepted, busy stays high.
        key_delay = 0;
        @(negedge clk);
        start_block(K_C1, P_C1, C_C1);
        wait_done(30, 0);
        check("b2b_ack_count", 128'(ack_cnt), 128'(11));
        start_block(K_B, P_B, C_B);
        check("b2b_done_high", 128'(done), 128'(1));
        wait_done(30, 0);
        check("b2b_ack_count2", 128'(ack_cnt), 128'(11));
        @(negedge clk);
        check("b2b_done_one_cycle", 128'(done), 128'(0));

        // Wrong key index for two cycles in the round-1 wait.
        bad_cnt = 2;
        run_block(K_B, P_B, C_B, 0, 32, 0, 1'b1);
        repeat (3) @(negedge clk);
        check("key_err_sticky", 128'(key_err), 128'(1));
        run_block(K_C1, P_C1, C_C1, 0, 30, 0, 1'b0);

        // Reset in round 5 with key_err set and data_out non-zero.
        key_delay = 0;
        bad_cnt = 2;
        @(negedge clk);
        start_block(K_B, P_B, C_B);
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check("pre_rst_key_err", 128'(key_err), 128'(1));
        check("pre_rst_busy", 128'(busy), 128'(1));
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_done", 128'(done), 128'(0));
        check("mid_rst_key_ack", 128'(key_ack), 128'(0));
        check("mid_rst_key_err", 128'(key_err), 128'(0));
        check("mid_rst_data_out", data_out, 128'(0));
        sb.delete();
        bad_cnt = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_block(K_C1, P_C1, C_C1, 0, 30, 0, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
